// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave keypad entry, BCD countdown, door/pause FSM and magnetron duty control
module cook_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DONE_BEEP_S = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keyboard,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic [3:0] power_lvl,
  output logic [3:0] minutos,
  output logic [3:0] dezenas,
  output logic [3:0] unidades,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = DONE_BEEP_S > 1 ? $clog2(DONE_BEEP_S) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_q;
  logic [3:0]    min_q, ten_q, one_q;
  logic [3:0]    phase_q, pwr_q;
  logic [DW-1:0] div_q;
  logic [BW-1:0] bcnt_q;
  logic [9:0]    kb_q;
  logic          beep_q;

  logic          key_press, tick, time_nz, dec_zero;
  logic [3:0]    digit, min_dec, ten_dec, one_dec, pwr_sel, phase_inc;

  // Decode the keypad edge, the 1 s tick and the next BCD countdown value
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) digit = keyboard[i] ? 4'(i) : digit;
    key_press = $onehot(keyboard) && kb_q == 10'd0;
    tick      = (state_q == COOKING || state_q == DONE) && div_q == DW'(TICK_DIV - 1);
    time_nz   = {min_q, ten_q, one_q} != 12'd0;
    one_dec   = one_q != 4'd0 ? one_q - 4'd1 : 4'd9;
    ten_dec   = one_q != 4'd0 ? ten_q : ten_q != 4'd0 ? ten_q - 4'd1 : 4'd5;
    min_dec   = (one_q != 4'd0 || ten_q != 4'd0) ? min_q : min_q - 4'd1;
    dec_zero  = {min_dec, ten_dec, one_dec} == 12'd0;
    pwr_sel   = (power_lvl == 4'd0 || power_lvl > 4'd10) ? 4'd10 : power_lvl;
    phase_inc = phase_q == 4'd9 ? 4'd0 : phase_q + 4'd1;
  end

  // Main controller: event priority is clear, door open, stop, start, tick, digit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
      div_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 4'd0;
      pwr_q   <= 4'd10;
      kb_q    <= 10'd0;
      beep_q  <= 1'b0;
    end else begin
      kb_q <= keyboard;
      if (clear) begin
        state_q <= IDLE;
        min_q   <= 4'd0;
        ten_q   <= 4'd0;
        one_q   <= 4'd0;
        phase_q <= 4'd0;
        beep_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, ENTRY: begin
            if (stop) begin
              state_q <= IDLE;
              min_q   <= 4'd0;
              ten_q   <= 4'd0;
              one_q   <= 4'd0;
            end else if (start) begin
              if (door_closed && time_nz) begin
                state_q <= COOKING;
                div_q   <= '0;
                pwr_q   <= pwr_sel;
                phase_q <= 4'd0;
              end
            end else if (key_press) begin
              state_q <= ENTRY;
              min_q   <= ten_q;
              ten_q   <= one_q;
              one_q   <= digit;
            end
          end
          COOKING: begin
            if (!door_closed || stop) begin
              state_q <= PAUSED;
            end else if (tick) begin
              min_q   <= min_dec;
              ten_q   <= ten_dec;
              one_q   <= one_dec;
              phase_q <= phase_inc;
              div_q   <= '0;
              if (dec_zero) begin
                state_q <= DONE;
                bcnt_q  <= '0;
                beep_q  <= 1'b1;
              end
            end else begin
              div_q <= div_q + DW'(1);
            end
          end
          PAUSED: begin
            if (stop) begin
              state_q <= IDLE;
              min_q   <= 4'd0;
              ten_q   <= 4'd0;
              one_q   <= 4'd0;
            end else if (start && door_closed && time_nz) begin
              state_q <= COOKING;
              div_q   <= '0;
              pwr_q   <= pwr_sel;
            end
          end
          DONE: begin
            if (key_press || start || stop) begin
              state_q <= IDLE;
              beep_q  <= 1'b0;
            end else if (tick) begin
              div_q <= '0;
              if (bcnt_q == BW'(DONE_BEEP_S - 1)) begin
                state_q <= IDLE;
                beep_q  <= 1'b0;
              end else begin
                bcnt_q <= bcnt_q + BW'(1);
              end
            end else begin
              div_q <= div_q + DW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mag_on   = state_q == COOKING && door_closed && phase_q < pwr_q;
  assign minutos  = min_q;
  assign dezenas  = ten_q;
  assign unidades = one_q;
  assign beep     = beep_q;
  assign state    = state_q;
endmodule

// File: tb/tb_cook_sequencer.sv
// tb_cook_sequencer: randomized scoreboard bench against a behavioural microwave model
module tb_cook_sequencer;
  localparam int TD = 4;
  localparam int BEEPS = 3;
  localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSED = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] keyboard = 10'd0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, door_closed = 1'b1;
  logic [3:0] power_lvl = 4'd10;
  logic [3:0] minutos, dezenas, unidades;
  logic       mag_on, beep;
  logic [2:0] state;

  cook_sequencer #(.TICK_DIV(TD), .DONE_BEEP_S(BEEPS)) dut (
    .clk(clk), .rst(rst), .keyboard(keyboard), .start(start), .stop(stop),
    .clear(clear), .door_closed(door_closed), .power_lvl(power_lvl),
    .minutos(minutos), .dezenas(dezenas), .unidades(unidades),
    .mag_on(mag_on), .beep(beep), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, mn, tn, on, bp, mg;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model state: time as three digits, countdowns to the next tick and to the end of the beep
  int m_st = S_IDLE, m_min = 0, m_ten = 0, m_one = 0;
  int m_ph = 0, m_pwr = 10, m_left = TD, m_bleft = 0, m_beep = 0;
  logic [9:0] m_kb = 10'd0;

  task automatic clear_time();
    m_min = 0; m_ten = 0; m_one = 0;
  endtask

  task automatic count_down();
    if (m_one > 0) m_one--;
    else if (m_ten > 0) begin m_ten--; m_one = 9; end
    else begin m_min--; m_ten = 5; m_one = 9; end
  endtask

  task automatic model_step();
    bit press, nz;
    int dig;
    press = $countones(keyboard) == 1 && m_kb == 10'd0;
    dig = 0;
    for (int i = 0; i < 10; i++) if (keyboard[i]) dig = i;
    nz = (m_min + m_ten + m_one) != 0;
    m_kb = keyboard;
    if (rst) begin
      m_st = S_IDLE; clear_time(); m_ph = 0; m_pwr = 10; m_left = TD; m_beep = 0; m_kb = 10'd0;
    end else if (clear) begin
      m_st = S_IDLE; clear_time(); m_ph = 0; m_beep = 0;
    end else if (m_st == S_COOK && !door_closed) begin
      m_st = S_PAUSED;
    end else if (stop) begin
      if (m_st == S_COOK) m_st = S_PAUSED;
      else begin m_st = S_IDLE; clear_time(); m_beep = 0; end
    end else if (start && m_st != S_COOK) begin
      if (m_st == S_DONE) begin
        m_st = S_IDLE; m_beep = 0;
      end else if (door_closed && nz) begin
        if (m_st != S_PAUSED) m_ph = 0;
        m_pwr = (power_lvl == 0 || power_lvl > 10) ? 10 : int'(power_lvl);
        m_left = TD;
        m_st = S_COOK;
      end
    end else if (m_st == S_DONE && press) begin
      m_st = S_IDLE; m_beep = 0;
    end else if (m_st == S_COOK || m_st == S_DONE) begin
      if (m_left > 1) m_left--;
      else begin
        m_left = TD;
        if (m_st == S_COOK) begin
          count_down();
          m_ph = (m_ph + 1) % 10;
          if (m_min + m_ten + m_one == 0) begin m_st = S_DONE; m_bleft = BEEPS; m_beep = 1; end
        end else begin
          m_bleft--;
          if (m_bleft == 0) begin m_st = S_IDLE; m_beep = 0; end
        end
      end
    end else if (press && (m_st == S_IDLE || m_st == S_ENTRY)) begin
      m_min = m_ten; m_ten = m_one; m_one = dig; m_st = S_ENTRY;
    end
  endtask

  // one clock: record expected mag_on now and expected registers after the edge
  task automatic cyc();
    exp_t e;
    e.mg = (m_st == S_COOK && door_closed && m_ph < m_pwr) ? 1 : 0;
    model_step();
    e.st = m_st; e.mn = m_min; e.tn = m_ten; e.on = m_one; e.bp = m_beep;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int d);
    keyboard = 10'b1 << d; cyc();
    keyboard = 10'd0; cyc();
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: mag_on is combinational so it is checked before the edge, registers after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mag_on", int'(mag_on), e.mg);
        @(posedge clk);
        #2;
        chk("state", int'(state), e.st);
        chk("minutos", int'(minutos), e.mn);
        chk("dezenas", int'(dezenas), e.tn);
        chk("unidades", int'(unidades), e.on);
        chk("beep", int'(beep), e.bp);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int r, len;
    @(posedge clk);
    #1;
    idle(3);
    rst = 1'b0;
    press(1); press(3); press(0);
    keyboard = 10'b1 << 3; idle(5);
    keyboard = 10'd0; cyc();
    keyboard = 10'h018; idle(2);
    keyboard = 10'd0; idle(2);
    do_clear(); press(3); power_lvl = 4'd10; do_start(); idle(30);
    do_clear(); press(1); press(0); press(0); do_start(); idle(10);
    do_clear(); press(7); press(0); do_start(); idle(10);
    do_clear(); press(2); press(0); power_lvl = 4'd3; do_start(); idle(45);
    do_clear(); press(1); press(0); power_lvl = 4'd10; do_start(); idle(8);
    door_closed = 1'b0; idle(3); do_start(); idle(2);
    door_closed = 1'b1; idle(1); do_start(); idle(10);
    do_stop(); idle(1); do_stop(); idle(2);
    do_clear(); do_start(); idle(2);
    press(5); do_start(); idle(5); do_clear(); idle(2);
    press(1); do_start(); idle(6); rst = 1'b1; cyc(); rst = 1'b0; idle(3);
    press(1); do_start(); idle(6); press(4); idle(2);
    do_clear(); press(1); do_start(); idle(7); do_start(); idle(2);
    power_lvl = 4'd0; press(2); do_start(); idle(20);
    for (int it = 0; it < 25; it++) begin
      do_clear();
      press(($urandom_range(0, 3) == 0) ? 1 : 0);
      press($urandom_range(0, 2));
      press($urandom_range(0, 9));
      power_lvl = 4'($urandom_range(0, 15));
      door_closed = 1'b1;
      do_start();
      len = $urandom_range(40, 250);
      for (int c = 0; c < len; c++) begin
        r = $urandom_range(0, 999);
        start = r < 10;
        stop  = r >= 10 && r < 15;
        clear = r >= 15 && r < 18;
        rst   = r >= 18 && r < 20;
        if (door_closed) door_closed = !(r >= 20 && r < 28);
        else door_closed = $urandom_range(0, 9) == 0;
        if (keyboard != 10'd0) keyboard = 10'd0;
        else if (r >= 30 && r < 45) keyboard = 10'b1 << $urandom_range(0, 9);
        else if (r >= 45 && r < 48) keyboard = 10'h018;
        power_lvl = 4'($urandom_range(0, 15));
        cyc();
      end
      start = 1'b0; stop = 1'b0; clear = 1'b0; rst = 1'b0; keyboard = 10'd0; door_closed = 1'b1;
      idle(2);
    end
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Central controller for the microwave datapath.
- Captures keypad digits into a BCD M:SS cook time and runs the start/stop/pause/door state machine.
- Generates its own 1 Hz tick, counts the time down, and pulses the magnetron with a power-level duty cycle.
- Outputs feed the existing 7-segment decoder (BCD digits) and the magnetron drive (mag_on).

Parameters:
- TICK_DIV, 50_000_000, clk cycles per 1 s tick (benches use 4).
- DONE_BEEP_S, 3, ticks that beep stays high in DONE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- keyboard  input  10  one-hot digit keys; bit i = digit i; level, held while pressed.
- start  input  1  active-high, one-cycle pulse.
- stop  input  1  active-high, one-cycle pulse.
- clear  input  1  active-high, one-cycle pulse.
- door_closed  input  1  1 = door closed.
- power_lvl  input  4  power level 1..10, sampled on entry to COOKING.
- minutos  output  4  BCD minutes.
- dezenas  output  4  BCD seconds tens.
- unidades  output  4  BCD seconds ones.
- mag_on  output  1  magnetron enable.
- beep  output  1  done indicator.
- state  output  3  FSM state (debug).

Behaviour:
- State encoding: IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4.
- Reset: state=IDLE; all digits 0; divider 0; phase 0; latched power 10; key history 0; beep=0; mag_on=0.
- Key press: keyboard is one-hot and the registered previous value was 0. Multi-hot or held keys are ignored.
- Digit entry (IDLE/ENTRY only): shift left: minutos<=dezenas, dezenas<=unidades, unidades<=digit. IDLE->ENTRY. Digits are not range-checked; dezenas may be 6..9.
- Per-cycle event priority: rst > clear > door open (COOKING only) > stop > start > tick > digit.
- clear, any state: ->IDLE, digits 0, phase 0.
- start in IDLE/ENTRY/PAUSED:
  - Moves to COOKING only if door_closed=1 and time != 0:00; otherwise ignored.
  - Divider resets to 0.
  - Latches power_lvl; values 0 or >10 are treated as 10.
  - From IDLE/ENTRY, phase resets to 0; from PAUSED, phase is retained.
- COOKING:
  - Divider counts 0..TICK_DIV-1; tick = one-cycle pulse at TICK_DIV-1, then divider wraps to 0.
  - On tick, BCD decrement:
    - ones>0: ones-1.
    - else tens>0: tens-1, ones=9.
    - else min>0: min-1, tens=5, ones=9.
  - On tick, phase increments 0..9 and wraps to 0.
  - If a tick brings the time to 0:00: ->DONE, divider 0, beep counter 0.
- Door open while COOKING: ->PAUSED on the next edge. Digits are frozen.
- stop: COOKING->PAUSED. PAUSED->IDLE with digits cleared. In IDLE/ENTRY, stop clears digits and goes to IDLE.
- PAUSED: divider frozen, no ticks, digit keys ignored.
- mag_on (combinational): (state==COOKING) && door_closed && (phase < latched power). mag_on drops in the same cycle the door opens.
- DONE:
  - beep=1. Divider runs; beep counter increments on each tick.
  - After DONE_BEEP_S ticks: ->IDLE, beep=0.
  - Any key press, start, stop or clear: immediate ->IDLE, beep=0; start does not restart cooking.
- A tick and a stop in the same cycle: stop wins, no decrement.
- Outputs minutos/dezenas/unidades, beep and state are registered. Time digits hold 0:00 in DONE.

Test Plan:
- Reset, press 1, 3, 0 (each 1 cycle, released between presses) -> digits 1:30, state=ENTRY. Holding '3' for 5 cycles shifts once. Pressing 3 and 4 together (keyboard=0x018) causes no shift.
- Enter 0:03, power_lvl=10, door closed, start (TICK_DIV=4) -> mag_on=1 continuously; 0:02, 0:01, 0:00 at 4-cycle spacing; DONE, beep=1 for 3 ticks (12 cycles), then IDLE.
- Enter 1:00, start, one tick -> 0:59. Entering 0:70 -> decrements to 0:69.
- Enter 0:20, power_lvl=3, start -> mag_on high for ticks phase 0-2 and low for phase 3-9 (12 cycles high, 28 low per 40-cycle window).
- Enter 0:10, start, open door after 2 ticks -> mag_on=0 same cycle, state=PAUSED, digits 0:08. Start with door open is ignored. Close door, start -> resumes from 0:08. stop twice -> IDLE, digits 0:00.
- Start at time 0:00 is ignored (state stays IDLE). clear mid-COOKING -> IDLE, mag_on=0, digits 0. rst asserted mid-DONE -> reset values on the next edge.
